// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port fixed-latency memory between fetch and data stages.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_MAX back-to-back data grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       run, own_dm, own_we, force_if;
  // run holds off grants until the first edge after reset is released
`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve;
  assign force_if = if_req & (starve == 4'(STARVE_MAX));
  always_ff @(posedge clk or negedge rst)
    if (!rst) starve <= '0;
    else if (!if_req || if_gnt) starve <= '0;
    else if (dm_gnt) starve <= starve + 4'd1;
`else
  assign force_if = STARVE_MAX < 0;
`endif
  always_comb begin
    dm_gnt    = run & (state == IDLE) & dm_req & ~force_if;
    if_gnt    = run & (state == IDLE) & if_req & ~dm_gnt;
    mem_en    = dm_gnt | if_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_addr  = dm_gnt ? dm_addr : if_gnt ? if_addr : '0;
    mem_wdata = dm_gnt ? dm_wdata : '0;
    state_nx  = mem_en ? WAIT : (state == WAIT && cnt == 4'd1) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      run       <= 1'b0;
      own_dm    <= 1'b0;
      own_we    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      run       <= 1'b1;
      state     <= state_nx;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if (mem_en) begin
        cnt    <= 4'(MEM_LAT);
        own_dm <= dm_gnt;
        own_we <= mem_we;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          if (own_dm) begin
            dm_rvalid <= 1'b1;
            if (!own_we) dm_rdata <= mem_rdata;
          end else begin
            if_rvalid <= 1'b1;
            if_rdata  <= mem_rdata;
          end
        end
      end
    end
  end
  assign stall_if  = if_req & ~if_rvalid;
  assign stall_mem = dm_req & ~dm_rvalid;
  assign busy      = state != IDLE;
endmodule
